cla_word_serial_adder: RTL

- Multi-cycle WIDTH-bit adder that processes operands 8 bits per cycle through one 8-bit carry-lookahead slice.
- Slice carry-out is registered and fed back as the next slice's carry-in; the word-level carry ripples through the register, not through combinational logic.
- Sits directly around the 8-bit CLA carry logic: it feeds p/g/carry-in and consumes the bit-7 carry-out.
- Valid/ready handshakes on input and output.

---
 rtl/cla_pkg.sv | 26 ++
 rtl/cla_8bit_slice.sv | 54 +++++
 rtl/cla_word_serial_adder.sv | 134 +++++++++++++
 3 files changed

// File: rtl/cla_pkg.sv
// -----------------------------------------------------------------------------
// cla_pkg
// Shared definitions for the word-serial carry-lookahead adder.
//   SLICE_W      : bits handled per cycle by the lookahead slice
//   state_e      : controller states (idle / running slices / result held)
//   idx_width()  : width of the slice index counter for a given slice count
// -----------------------------------------------------------------------------
package cla_pkg;

    localparam int unsigned SLICE_W = 8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // A one-slice adder still needs a 1-bit index so the counter is never zero-width.
    function automatic int unsigned idx_width(input int unsigned nslice);
        if (nslice <= 1) begin
            return 1;
        end
        return $clog2(nslice);
    endfunction

endpackage

// File: rtl/cla_8bit_slice.sv
// -----------------------------------------------------------------------------
// cla_8bit_slice
// Combinational 8-bit carry-lookahead adder slice.
// Ports:
//   a_i[7:0], b_i[7:0] : slice operands
//   cin_i              : carry into bit 0
//   s_o[7:0]           : slice sum
//   c7_o               : carry into bit 7 (used for signed overflow)
//   cout_o             : carry out of bit 7
// -----------------------------------------------------------------------------
module cla_8bit_slice
    import cla_pkg::*;
(
    input  logic [SLICE_W-1:0] a_i,
    input  logic [SLICE_W-1:0] b_i,
    input  logic               cin_i,
    output logic [SLICE_W-1:0] s_o,
    output logic               c7_o,
    output logic               cout_o
);

    logic [SLICE_W-1:0] p;
    logic [SLICE_W-1:0] g;
    logic [SLICE_W:0]   c;

    assign p = a_i ^ b_i;
    assign g = a_i & b_i;

    // Full lookahead: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i]..p[0]cin.
    // Every carry is a flat sum of products of p/g/cin; no carry feeds another.
    always_comb begin
        logic cx;
        logic prod;
        c    = '0;
        cx   = 1'b0;
        prod = 1'b0;
        c[0] = cin_i;
        for (int i = 0; i < int'(SLICE_W); i++) begin
            cx   = g[i];
            prod = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                cx   = cx | (prod & g[j]);
                prod = prod & p[j];
            end
            cx       = cx | (prod & cin_i);
            c[i + 1] = cx;
        end
    end

    assign s_o    = p ^ c[SLICE_W-1:0];
    assign c7_o   = c[SLICE_W-1];
    assign cout_o = c[SLICE_W];

endmodule

// File: rtl/cla_word_serial_adder.sv
// -----------------------------------------------------------------------------
// cla_word_serial_adder
// Multi-cycle WIDTH-bit adder: one 8-bit lookahead slice is reused NSLICE times,
// with the slice carry-out registered and fed back as the next slice carry-in.
// Ports:
//   clk_i, rst_ni            : clock, synchronous active-low reset
//   in_valid_i / in_ready_o  : operand handshake (accepted only when idle)
//   a_i, b_i, cin_i          : operands and word carry-in
//   out_valid_o / out_ready_i: result handshake (result held until taken)
//   sum_o                    : (a + b + cin) mod 2^WIDTH
//   cout_o                   : carry out of bit WIDTH-1
//   overflow_o               : two's-complement overflow
// -----------------------------------------------------------------------------
module cla_word_serial_adder
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             overflow_o
);

    localparam int unsigned NSLICE = WIDTH / SLICE_W;
    localparam int unsigned IdxW   = idx_width(NSLICE);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NSLICE - 1);

    if ((WIDTH < SLICE_W) || ((WIDTH % SLICE_W) != 0)) begin : gen_width_check
        $error("cla_word_serial_adder: WIDTH must be a multiple of 8 and at least 8");
    end

    state_e                          state_q, state_d;
    logic [IdxW-1:0]                 idx_q, idx_d;
    logic                            carry_q, carry_d;
    logic [NSLICE-1:0][SLICE_W-1:0]  a_q, a_d;
    logic [NSLICE-1:0][SLICE_W-1:0]  b_q, b_d;
    logic [NSLICE-1:0][SLICE_W-1:0]  sum_q, sum_d;
    logic                            cout_q, cout_d;
    logic                            ovf_q, ovf_d;

    logic [SLICE_W-1:0] slice_s;
    logic               slice_c7;
    logic               slice_cout;

    cla_8bit_slice u_slice (
        .a_i    (a_q[idx_q]),
        .b_i    (b_q[idx_q]),
        .cin_i  (carry_q),
        .s_o    (slice_s),
        .c7_o   (slice_c7),
        .cout_o (slice_cout)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    carry_d = cin_i;
                    idx_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                sum_d[idx_q] = slice_s;
                carry_d      = slice_cout;
                if (idx_q == LastIdx) begin
                    // The top slice's bit 7 is the word MSB, so its c7/c8 give overflow.
                    cout_d  = slice_cout;
                    ovf_d   = slice_c7 ^ slice_cout;
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + IdxW'(1);
                end
            end
            StDone: begin
                if (out_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign in_ready_o  = (state_q == StIdle);
    assign out_valid_o = (state_q == StDone);
    assign sum_o       = sum_q;
    assign cout_o      = cout_q;
    assign overflow_o  = ovf_q;

endmodule
